// File: rtl/delay_sweep_ctrl.sv
// delay_sweep_ctrl
// Steps a trigger-to-output delay from cfg_start to cfg_stop in cfg_step
// increments. It takes cfg_repeat triggers at each delay point and waits for
// the output datapath to go idle after every shot. All outputs are registered,
// so they clear asynchronously with rst.
//
// Timing of a delay point: entering LOAD presents the new delay_cycles value.
// The delay_update strobe follows one cycle later, while the FSM is still in
// LOAD. This means the datapath always samples a value that has been stable
// for a full cycle, and a valid arm produces delay_update exactly two cycles
// after the arm pulse.

module delay_sweep_ctrl #(
    parameter int DELAY_BITS = 32,
    parameter int COUNT_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DELAY_BITS-1:0] cfg_start,
    input  logic [DELAY_BITS-1:0] cfg_stop,
    input  logic [DELAY_BITS-1:0] cfg_step,
    input  logic [COUNT_BITS-1:0] cfg_repeat,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  trigger_pulse,
    input  logic                  out_busy,
    output logic [DELAY_BITS-1:0] delay_cycles,
    output logic                  delay_update,
    output logic                  armed,
    output logic                  done,
    output logic                  cfg_error,
    output logic [COUNT_BITS-1:0] point_index,
    output logic [COUNT_BITS-1:0] shot_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ARMED,
        WAIT_OUT,
        ADVANCE,
        DONE
    } state_e;

    localparam logic [COUNT_BITS-1:0] CNT_ONE = COUNT_BITS'(1);

    state_e                  state_q, state_d;
    logic [DELAY_BITS-1:0]   cur_q, cur_d;
    logic [DELAY_BITS-1:0]   stop_q, stop_d;
    logic [DELAY_BITS-1:0]   step_q, step_d;
    logic [COUNT_BITS-1:0]   repeat_q, repeat_d;
    logic [COUNT_BITS-1:0]   point_q, point_d;
    logic [COUNT_BITS-1:0]   shot_q, shot_d;
    logic [DELAY_BITS-1:0]   delay_cycles_q, delay_cycles_d;
    logic                    delay_update_q, delay_update_d;
    logic                    armed_q, armed_d;
    logic                    done_q, done_d;
    logic                    cfg_error_q, cfg_error_d;
    // Set during the second LOAD cycle, which is the one carrying the strobe.
    logic                    load_phase_q, load_phase_d;
    // Set once WAIT_OUT has been held for its minimum first cycle.
    logic                    wait_min_q, wait_min_d;

    // Extra bit so that a wrap past the top of the delay range is visible as a carry.
    logic [DELAY_BITS:0]     next_sum;
    logic                    cfg_bad;

    // Next-state and next-output logic for the sweep FSM.
    always_comb begin
        // NOTE: every *_d gets a default before the case so that no path leaves it unassigned; otherwise a latch is inferred.
        state_d        = state_q;
        cur_d          = cur_q;
        stop_d         = stop_q;
        step_d         = step_q;
        repeat_d       = repeat_q;
        point_d        = point_q;
        shot_d         = shot_q;
        delay_cycles_d = delay_cycles_q;
        delay_update_d = 1'b0;
        cfg_error_d    = cfg_error_q;
        load_phase_d   = load_phase_q;
        wait_min_d     = wait_min_q;

        next_sum = {1'b0, cur_q} + {1'b0, step_q};
        cfg_bad  = (cfg_step == '0) || (cfg_repeat == '0) || (cfg_start > cfg_stop);

        if (abort) begin
            // Abort cancels the sweep. The delay value and the counters keep
            // their last values so software can see where the sweep stopped.
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (arm) begin
                        stop_d   = cfg_stop;
                        step_d   = cfg_step;
                        repeat_d = cfg_repeat;
                        if (cfg_bad) begin
                            cfg_error_d = 1'b1;
                            state_d     = IDLE;
                        end else begin
                            cfg_error_d    = 1'b0;
                            cur_d          = cfg_start;
                            delay_cycles_d = cfg_start;
                            point_d        = '0;
                            shot_d         = '0;
                            load_phase_d   = 1'b0;
                            state_d        = LOAD;
                        end
                    end
                end

                LOAD: begin
                    if (!load_phase_q) begin
                        load_phase_d   = 1'b1;
                        delay_update_d = 1'b1;
                    end else begin
                        state_d = ARMED;
                    end
                end

                ARMED: begin
                    if (trigger_pulse) begin
                        wait_min_d = 1'b0;
                        state_d    = WAIT_OUT;
                    end
                end

                WAIT_OUT: begin
                    if (!wait_min_q) begin
                        wait_min_d = 1'b1;
                    end else if (!out_busy) begin
                        shot_d  = shot_q + CNT_ONE;
                        state_d = (shot_d < repeat_q) ? ARMED : ADVANCE;
                    end
                end

                ADVANCE: begin
                    if (next_sum[DELAY_BITS] || (next_sum[DELAY_BITS-1:0] > stop_q)) begin
                        state_d = DONE;
                    end else begin
                        cur_d          = next_sum[DELAY_BITS-1:0];
                        delay_cycles_d = next_sum[DELAY_BITS-1:0];
                        // point_index is only a report and wraps freely; termination is set by the delay compare alone.
                        point_d        = point_q + CNT_ONE;
                        shot_d         = '0;
                        load_phase_d   = 1'b0;
                        state_d        = LOAD;
                    end
                end

                default: state_d = IDLE;
            endcase
        end

        // Decode the status outputs from the next state so they are registered
        // and line up with the state they describe.
        armed_d = (state_d == ARMED);
        done_d  = (state_d == DONE);
    end

    // State and output registers; rst clears everything, including delay_cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cur_q          <= '0;
            stop_q         <= '0;
            step_q         <= '0;
            repeat_q       <= '0;
            point_q        <= '0;
            shot_q         <= '0;
            delay_cycles_q <= '0;
            delay_update_q <= 1'b0;
            armed_q        <= 1'b0;
            done_q         <= 1'b0;
            cfg_error_q    <= 1'b0;
            load_phase_q   <= 1'b0;
            wait_min_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge values, whatever the statement order.
            state_q        <= state_d;
            cur_q          <= cur_d;
            stop_q         <= stop_d;
            step_q         <= step_d;
            repeat_q       <= repeat_d;
            point_q        <= point_d;
            shot_q         <= shot_d;
            delay_cycles_q <= delay_cycles_d;
            delay_update_q <= delay_update_d;
            armed_q        <= armed_d;
            done_q         <= done_d;
            cfg_error_q    <= cfg_error_d;
            load_phase_q   <= load_phase_d;
            wait_min_q     <= wait_min_d;
        end
    end

    assign delay_cycles = delay_cycles_q;
    assign delay_update = delay_update_q;
    assign armed        = armed_q;
    assign done         = done_q;
    assign cfg_error    = cfg_error_q;
    assign point_index  = point_q;
    assign shot_count   = shot_q;

endmodule
